// File: rtl/gate_chk_pkg.sv
// Shared definitions for the gate response checker: FSM states, widths and
// a mismatch-counting helper.
package gate_chk_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        CHECK,
        DONE
    } state_t;

    localparam int NUM_VECTORS = 4;
    localparam int VEC_W       = $clog2(NUM_VECTORS);
    localparam int ERR_W       = 4;
    localparam int CNT_W       = 8;

    // Number of set bits in a 3-bit mismatch mask (0..3).
    function automatic logic [ERR_W-1:0] count_mismatch(input logic [2:0] diff);
        return ERR_W'(diff[0]) + ERR_W'(diff[1]) + ERR_W'(diff[2]);
    endfunction

endpackage

// File: rtl/gate_golden.sv
// Reference model of the gates under test: expected and/or/not for (a, b).
module gate_golden (
    input  logic a,
    input  logic b,
    output logic exp_and,
    output logic exp_or,
    output logic exp_not
);

    // Pure combinational golden responses.
    always_comb begin
        exp_and = a & b;
        exp_or  = a | b;
        exp_not = ~a;
    end

endmodule

// File: rtl/gate_resp_checker.sv
// Walks all four {a,b} input vectors, lets the external gates settle, then
// compares their responses with the golden model and reports the result.
module gate_resp_checker #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       outputand,
    input  logic       outputor,
    input  logic       outputnot,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [1:0] first_fail_vec,
    output logic       first_fail_valid
);

    import gate_chk_pkg::*;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [VEC_W-1:0] VEC_LAST    = VEC_W'(NUM_VECTORS - 1);

    state_t            state;
    logic [VEC_W-1:0]  vec;
    logic [CNT_W-1:0]  settle_cnt;
    logic              exp_and;
    logic              exp_or;
    logic              exp_not;
    logic [2:0]        diff;
    logic [ERR_W-1:0]  mism;

    // a/b are registered copies of vec, so the golden model sees the applied vector.
    gate_golden u_golden (
        .a       (a),
        .b       (b),
        .exp_and (exp_and),
        .exp_or  (exp_or),
        .exp_not (exp_not)
    );

    // Per-bit mismatch between observed and expected responses.
    always_comb begin
        diff = {outputand ^ exp_and, outputor ^ exp_or, outputnot ^ exp_not};
        mism = count_mismatch(diff);
    end

    // Run sequencer: drive each vector, settle, check, then report.
    // {a,b} is loaded with the next vec on each transition into DRIVE so that
    // it tracks vec throughout DRIVE/CHECK while every output stays registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            vec              <= '0;
            settle_cnt       <= '0;
            a                <= 1'b0;
            b                <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state            <= DRIVE;
                        vec              <= '0;
                        settle_cnt       <= '0;
                        err_count        <= '0;
                        first_fail_valid <= 1'b0;
                        pass             <= 1'b0;
                        busy             <= 1'b1;
                        {a, b}           <= 2'b00;
                    end
                end
                DRIVE: begin
                    settle_cnt <= settle_cnt + 1'b1;
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    err_count <= err_count + mism;
                    if (mism != '0 && !first_fail_valid) begin
                        first_fail_vec   <= vec;
                        first_fail_valid <= 1'b1;
                    end
                    if (vec == VEC_LAST) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        {a, b} <= 2'b00;
                    end else begin
                        state      <= DRIVE;
                        vec        <= vec + 1'b1;
                        settle_cnt <= '0;
                        {a, b}     <= vec + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    pass  <= (err_count == '0);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_resp_checker.sv
// Directed bench for gate_resp_checker: ideal gates, stuck-at faults, start
// held high, mid-run reset, and a second instance with SETTLE_CYCLES=1.
module tb_gate_resp_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       start0, start1;
    logic       fault_and0, fault_not1;
    logic       a0, b0, a1, b1;
    logic       oand0, oor0, onot0;
    logic       busy0, done0, pass0, ffvalid0;
    logic [3:0] err0;
    logic [1:0] ffv0;
    logic       busy1, done1, pass1, ffvalid1;
    logic [3:0] err1;
    logic [1:0] ffv1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Gates under test for instance 0, with injectable faults.
    assign oand0 = fault_and0 ? 1'b0 : (a0 & b0);
    assign oor0  = a0 | b0;
    assign onot0 = fault_not1 ? 1'b1 : ~a0;

    gate_resp_checker #(.SETTLE_CYCLES(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start0),
        .outputand        (oand0),
        .outputor         (oor0),
        .outputnot        (onot0),
        .a                (a0),
        .b                (b0),
        .busy             (busy0),
        .done             (done0),
        .pass             (pass0),
        .err_count        (err0),
        .first_fail_vec   (ffv0),
        .first_fail_valid (ffvalid0)
    );

    gate_resp_checker #(.SETTLE_CYCLES(1)) dut1 (
        .clk              (clk),
        .rst              (rst),
        .start            (start1),
        .outputand        (a1 & b1),
        .outputor         (a1 | b1),
        .outputnot        (~a1),
        .a                (a1),
        .b                (b1),
        .busy             (busy1),
        .done             (done1),
        .pass             (pass1),
        .err_count        (err1),
        .first_fail_vec   (ffv1),
        .first_fail_valid (ffvalid1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Start a run on instance 0 from a negedge; start is held for 'hold' edges.
    // lat = negedges after the start edge at which done is first seen (-1 if never).
    task automatic run0(input int hold, output int lat, output int ndone, output logic bmid);
        lat   = -1;
        ndone = 0;
        bmid  = 1'b0;
        start0 = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (k == hold - 1) start0 = 1'b0;
            if (k == 5) bmid = busy0;
            if (done0) begin
                ndone++;
                if (lat < 0) lat = k;
            end
        end
    endtask

    int   lat, ndone;
    logic bmid;
    logic [1:0] ab1 [8];
    int   lat1;
    bit   seen;

    initial begin
        rst        = 1'b1;
        start0     = 1'b0;
        start1     = 1'b0;
        fault_and0 = 1'b0;
        fault_not1 = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_ab",      {30'd0, a0, b0}, 0);
        chk("rst_busy",    busy0, 0);
        chk("rst_done",    done0, 0);
        chk("rst_pass",    pass0, 0);
        chk("rst_err",     err0, 0);
        chk("rst_ffvalid", ffvalid0, 0);
        rst = 1'b0;
        @(negedge clk);

        // Ideal run, SETTLE_CYCLES=4
        run0(1, lat, ndone, bmid);
        chk("ideal_lat",     lat, 21);
        chk("ideal_ndone",   ndone, 1);
        chk("ideal_busymid", bmid, 1);
        chk("ideal_pass",    pass0, 1);
        chk("ideal_err",     err0, 0);
        chk("ideal_ffvalid", ffvalid0, 0);
        chk("idle_busy",     busy0, 0);
        chk("idle_ab",       {30'd0, a0, b0}, 0);

        // outputand stuck at 0: only vector 11 fails
        fault_and0 = 1'b1;
        run0(1, lat, ndone, bmid);
        chk("and0_lat",     lat, 21);
        chk("and0_err",     err0, 1);
        chk("and0_ffv",     ffv0, 3);
        chk("and0_ffvalid", ffvalid0, 1);
        chk("and0_pass",    pass0, 0);
        fault_and0 = 1'b0;

        // outputnot stuck at 1: vectors 10 and 11 fail, first is 10
        fault_not1 = 1'b1;
        run0(1, lat, ndone, bmid);
        chk("not1_err",     err0, 2);
        chk("not1_ffv",     ffv0, 2);
        chk("not1_ffvalid", ffvalid0, 1);
        chk("not1_pass",    pass0, 0);
        repeat (10) @(negedge clk);
        chk("not1_hold_err", err0, 2);
        chk("not1_hold_ffv", ffv0, 2);
        fault_not1 = 1'b0;

        // start held high through most of the run: one run, one done
        run0(15, lat, ndone, bmid);
        chk("hold_lat",   lat, 21);
        chk("hold_ndone", ndone, 1);
        chk("hold_pass",  pass0, 1);

        // Reset while vector 10 is applied
        fault_not1 = 1'b1;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if ({a0, b0} == 2'b10) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("mid_reach_vec2", seen, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_ab",      {30'd0, a0, b0}, 0);
        chk("mid_busy",    busy0, 0);
        chk("mid_done",    done0, 0);
        chk("mid_pass",    pass0, 0);
        chk("mid_err",     err0, 0);
        chk("mid_ffv",     ffv0, 0);
        chk("mid_ffvalid", ffvalid0, 0);
        rst = 1'b0;
        fault_not1 = 1'b0;
        ndone = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (done0) ndone++;
        end
        chk("mid_nodone", ndone, 0);
        run0(1, lat, ndone, bmid);
        chk("post_lat",   lat, 21);
        chk("post_ndone", ndone, 1);
        chk("post_pass",  pass0, 1);
        chk("post_err",   err0, 0);

        // SETTLE_CYCLES=1 instance: 9-cycle run, vector changes every 2 cycles
        lat1 = -1;
        start1 = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (k == 0) start1 = 1'b0;
            if (k < 8) ab1[k] = {a1, b1};
            if (done1 && lat1 < 0) lat1 = k;
        end
        chk("s1_lat",  lat1, 9);
        chk("s1_pass", pass1, 1);
        chk("s1_err",  err1, 0);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("s1_ab%0d", k), {30'd0, ab1[k]}, k / 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
